// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: enable input and timing outputs of vga_sync_gen; VGA_SYNC_FRAME_COUNT_EN adds o_Frame_Count
interface vga_sync_gen_if;
    logic       i_Enable;
    logic       o_HSync;
    logic       o_VSync;
    logic       o_Active;
    logic       o_Frame_Start;
    logic [9:0] o_Col_Count;
    logic [9:0] o_Row_Count;
`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [7:0] o_Frame_Count;
    modport master (input i_Enable, output o_HSync, o_VSync, o_Active, o_Frame_Start,
                    o_Col_Count, o_Row_Count, o_Frame_Count);
    modport slave (output i_Enable, input o_HSync, o_VSync, o_Active, o_Frame_Start,
                   o_Col_Count, o_Row_Count, o_Frame_Count);
`else
    modport master (input i_Enable, output o_HSync, o_VSync, o_Active, o_Frame_Start,
                    o_Col_Count, o_Row_Count);
    modport slave (output i_Enable, input o_HSync, o_VSync, o_Active, o_Frame_Start,
                   o_Col_Count, o_Row_Count);
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator; define VGA_SYNC_FRAME_COUNT_EN to add an 8-bit frame counter
module vga_sync_gen #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2
) (
    input logic            i_Clk,
    input logic            i_Rst_L,
    vga_sync_gen_if.master bus
);
    localparam logic [1:0] H_ACTIVE = 2'd0, H_FRONT = 2'd1, H_SYNC = 2'd2, H_BACK = 2'd3;
    localparam logic [1:0] V_ACTIVE = 2'd0, V_FRONT = 2'd1, V_SYNC = 2'd2, V_BACK = 2'd3;
    localparam logic [9:0] LAST_COL      = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW      = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] H_FRONT_START = 10'(ACTIVE_COLS);
    localparam logic [9:0] H_SYNC_START  = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] H_BACK_START  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0] V_FRONT_START = 10'(ACTIVE_ROWS);
    localparam logic [9:0] V_SYNC_START  = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] V_BACK_START  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

    logic [9:0] col_q, row_q, col_n, row_n;
    logic [1:0] h_q, h_n, v_q, v_n;
    logic       col_wrap;

    assign bus.o_Col_Count = col_q;
    assign bus.o_Row_Count = row_q;

    // Next pixel and phases; outputs are registered from these so they describe the same pixel as the counts
    always_comb begin
        col_wrap = col_q == LAST_COL;
        col_n    = col_wrap ? '0 : col_q + 10'd1;
        row_n    = !col_wrap ? row_q : (row_q == LAST_ROW) ? '0 : row_q + 10'd1;
        h_n      = (col_n == '0)            ? H_ACTIVE :
                   (col_n == H_FRONT_START) ? H_FRONT  :
                   (col_n == H_SYNC_START)  ? H_SYNC   :
                   (col_n == H_BACK_START)  ? H_BACK   : h_q;
        v_n      = !col_wrap                ? v_q      :
                   (row_n == '0)            ? V_ACTIVE :
                   (row_n == V_FRONT_START) ? V_FRONT  :
                   (row_n == V_SYNC_START)  ? V_SYNC   :
                   (row_n == V_BACK_START)  ? V_BACK   : v_q;
    end

    // Counters, phase FSMs and decoded outputs; reset parks on the last pixel of the frame
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col_q             <= LAST_COL;
            row_q             <= LAST_ROW;
            h_q               <= H_BACK;
            v_q               <= V_BACK;
            bus.o_HSync       <= 1'b1;
            bus.o_VSync       <= 1'b1;
            bus.o_Active      <= 1'b0;
            bus.o_Frame_Start <= 1'b0;
        end else if (bus.i_Enable) begin
            col_q             <= col_n;
            row_q             <= row_n;
            h_q               <= h_n;
            v_q               <= v_n;
            bus.o_HSync       <= h_n != H_SYNC;
            bus.o_VSync       <= v_n != V_SYNC;
            bus.o_Active      <= (h_n == H_ACTIVE) && (v_n == V_ACTIVE);
            bus.o_Frame_Start <= (col_n == '0) && (row_n == '0);
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    // Frame counter bumps on the edge that enters (0,0), i.e. when o_Frame_Start rises
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            bus.o_Frame_Count <= 8'd0;
        else if (bus.i_Enable && col_n == '0 && row_n == '0)
            bus.o_Frame_Count <= bus.o_Frame_Count + 8'd1;
    end
`endif
endmodule
